// File: rtl/mem_lsu.sv
// Load/store unit between a core request port and a word-addressed memory.
// Performs alignment checks, byte-lane steering for stores, and load extraction and extension.
module mem_lsu #(
  parameter bit STORE_ACK = 1'b1
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_rready,
  output logic        mem_wready,
  output logic [29:0] mem_raddr,
  output logic [29:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DW = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_RSP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;

  logic            accept;
  logic            req_err;
  logic [DW-1:0]   ld_shift;
  logic [DW-1:0]   ld_data;

  // State and captured request context
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= S_IDLE;
      addr_lo_q   <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_lo_q   <= addr_lo_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Misaligned or illegal-size requests never reach memory
  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = |req_addr[1:0];
      default: req_err = 1'b1;
    endcase
  end

  // Right-align the addressed bytes of the returned word and extend to 32 bits
  always_comb begin
    ld_shift = mem_rdata >> {addr_lo_q, 3'b000};
    ld_data  = ld_shift;
    case (size_q)
      2'b00:   ld_data = {{24{~uns_q & ld_shift[7]}}, ld_shift[7:0]};
      2'b01:   ld_data = {{16{~uns_q & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  // Next-state and response register update
  always_comb begin
    state_d     = state_q;
    addr_lo_d   = addr_lo_q;
    size_d      = size_q;
    uns_d       = uns_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_lo_d = req_addr[1:0];
          size_d    = req_size;
          uns_d     = req_unsigned;
          if (req_err) begin
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end else if (!req_we) begin
            state_d = S_RD;
          end else if (STORE_ACK) begin
            state_d     = S_RSP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b0;
          end
        end
      end
      S_RD: begin
        state_d     = S_RSP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ld_data;
        rsp_err_d   = 1'b0;
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and memory-side outputs
  always_comb begin
    req_ready  = resetb & (state_q == S_IDLE);
    accept     = req_valid & req_ready;
    mem_rready = accept & ~req_we & ~req_err;
    mem_wready = accept & req_we & ~req_err;
    mem_raddr  = req_addr[31:2];
    mem_waddr  = req_addr[31:2];
    mem_wstrb  = 4'b0000;
    mem_wdata  = req_wdata;
    case (req_size)
      2'b00:   mem_wdata = {4{req_wdata[7:0]}};
      2'b01:   mem_wdata = {2{req_wdata[15:0]}};
      default: mem_wdata = req_wdata;
    endcase
    if (mem_wready) begin
      case (req_size)
        2'b00:   mem_wstrb = 4'(4'b0001 << req_addr[1:0]);
        2'b01:   mem_wstrb = 4'(4'b0011 << req_addr[1:0]);
        default: mem_wstrb = 4'b1111;
      endcase
    end
    rsp_valid = rsp_valid_q;
    rsp_rdata = rsp_rdata_q;
    rsp_err   = rsp_err_q;
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: byte-level memory model plus cycle-accurate expectations of every output.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        resetb;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_rready, mem_wready;
  logic [29:0] mem_raddr, mem_waddr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  mem_lsu dut (
    .clk(clk), .resetb(resetb),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_rready(mem_rready), .mem_wready(mem_wready),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory seen by the DUT (word array, aliased on the low 8 word-address bits)
  logic [31:0] dmem [256];
  // Reference memory as plain bytes, aliased on the low 10 byte-address bits
  logic [7:0]  ref_bytes [1024];

  // Expected per-cycle outputs
  logic        m_rst, m_ready, m_rready, m_wready, m_rsp_valid, m_err;
  logic [3:0]  m_wstrb;
  logic [31:0] m_wdata, m_rdata;

  logic [3:0]  last_wstrb;
  logic [29:0] last_waddr;
  logic [31:0] last_wdata, last_rdata;
  logic        last_err;

  always @(posedge clk) begin
    if (mem_wready)
      for (int i = 0; i < 4; i++)
        if (mem_wstrb[i]) dmem[mem_waddr[7:0]][8*i +: 8] = mem_wdata[8*i +: 8];
    if (mem_rready) mem_rdata <= dmem[mem_raddr[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("req_ready", 32'(req_ready), 32'(m_ready));
    chk("mem_rready", 32'(mem_rready), 32'(m_rready));
    chk("mem_wready", 32'(mem_wready), 32'(m_wready));
    chk("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
    chk("mem_raddr", 32'(mem_raddr), 32'(req_addr[31:2]));
    chk("mem_waddr", 32'(mem_waddr), 32'(req_addr[31:2]));
    chk("rw_exclusive", 32'(mem_rready & mem_wready), 32'd0);
    if (m_wready) chk("mem_wdata", mem_wdata, m_wdata);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
    if (m_rsp_valid) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    if (m_rst) begin
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_err", 32'(rsp_err), 32'd0);
    end
    if (mem_wready) begin
      last_wstrb = mem_wstrb;
      last_waddr = mem_waddr;
      last_wdata = mem_wdata;
    end
    if (rsp_valid && rsp_ready) begin
      last_rdata = rsp_rdata;
      last_err   = rsp_err;
    end
  end

  task automatic junk();
    req_valid    = 1'($urandom);
    req_we       = 1'($urandom);
    req_addr     = $urandom;
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_wdata    = $urandom;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request from IDLE through response handshake; entered and left at posedge+1
  task automatic xact(input logic we, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata, input int hold,
                      input bit rst_in_rd);
    int nb;
    int lane;
    logic err;
    logic [31:0] v;
    nb  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    err = (size == 2'b11) || ((addr % 32'(nb)) != 0);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    m_ready = 1'b1; m_rsp_valid = 1'b0;
    m_rready = !we && !err;
    m_wready = we && !err;
    m_wstrb = 4'b0; m_wdata = 32'b0; v = 32'b0;
    if (!err && we) begin
      for (int i = 0; i < 4; i++) begin
        lane = i - int'(addr[1:0]);
        if (lane >= 0 && lane < nb) m_wstrb[i] = 1'b1;
        m_wdata[8*i +: 8] = wdata[8*(i % nb) +: 8];
      end
      for (int k = 0; k < nb; k++) ref_bytes[(addr + 32'(k)) & 32'h3FF] = wdata[8*k +: 8];
    end else if (!err) begin
      for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_bytes[(addr + 32'(k)) & 32'h3FF];
      if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
    end
    step();
    junk();
    m_ready = 1'b0; m_rready = 1'b0; m_wready = 1'b0; m_wstrb = 4'b0;
    if (err) begin
      m_rsp_valid = 1'b1; m_rdata = 32'b0; m_err = 1'b1;
    end else if (we) begin
      m_rsp_valid = 1'b1; m_rdata = 32'b0; m_err = 1'b0;
    end else begin
      if (rst_in_rd) begin
        resetb = 1'b0; m_rst = 1'b1;
        step();
        resetb = 1'b1; m_rst = 1'b0; m_ready = 1'b1; req_valid = 1'b0;
        return;
      end
      step();
      junk();
      m_rsp_valid = 1'b1; m_rdata = v; m_err = 1'b0;
    end
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      step();
      junk();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0; req_valid = 1'b0;
    m_ready = 1'b1; m_rsp_valid = 1'b0;
  endtask

  initial begin
    logic        r_we;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    resetb = 1'b0; m_rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'b0; req_size = 2'b0;
    req_unsigned = 1'b0; req_wdata = 32'b0; rsp_ready = 1'b0;
    m_ready = 1'b0; m_rready = 1'b0; m_wready = 1'b0; m_rsp_valid = 1'b0;
    m_err = 1'b0; m_wstrb = 4'b0; m_wdata = 32'b0; m_rdata = 32'b0;
    last_wstrb = 4'b0; last_waddr = 30'b0; last_wdata = 32'b0;
    last_rdata = 32'b0; last_err = 1'b0;
    for (int w = 0; w < 256; w++) begin
      dmem[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_bytes[4*w + b] = dmem[w][8*b +: 8];
    end
    repeat (3) step();
    resetb = 1'b1; m_rst = 1'b0; m_ready = 1'b1;
    step();

    xact(1'b1, 32'h100, 2'b10, 1'b0, 32'h1122_3344, 0, 1'b0);
    chk("st_word_strb", 32'(last_wstrb), 32'hF);
    chk("st_word_waddr", 32'(last_waddr), 32'h40);
    xact(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 0, 1'b0);
    chk("ld_word", last_rdata, 32'h1122_3344);
    chk("ld_word_err", 32'(last_err), 32'd0);

    xact(1'b1, 32'h100, 2'b10, 1'b0, 32'h80FF_0000, 1, 1'b0);
    xact(1'b0, 32'h103, 2'b00, 1'b0, 32'h0, 0, 1'b0);
    chk("ld_byte_signed", last_rdata, 32'hFFFF_FF80);
    xact(1'b0, 32'h103, 2'b00, 1'b1, 32'h0, 0, 1'b0);
    chk("ld_byte_unsigned", last_rdata, 32'h0000_0080);

    xact(1'b1, 32'h102, 2'b01, 1'b0, 32'h0000_BEEF, 0, 1'b0);
    chk("st_half_strb", 32'(last_wstrb), 32'hC);
    chk("st_half_wdata", last_wdata, 32'hBEEF_BEEF);
    xact(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 0, 1'b0);
    chk("reload_word", last_rdata, 32'hBEEF_0000);

    xact(1'b0, 32'h101, 2'b10, 1'b0, 32'h0, 0, 1'b0);
    chk("misalign_err", 32'(last_err), 32'd1);
    chk("misalign_rdata", last_rdata, 32'd0);
    xact(1'b0, 32'h0, 2'b11, 1'b0, 32'h0, 0, 1'b0);
    chk("size3_err", 32'(last_err), 32'd1);

    xact(1'b0, 32'h102, 2'b01, 1'b1, 32'h0, 5, 1'b0);
    chk("held_rsp", last_rdata, 32'h0000_BEEF);

    xact(1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 0, 1'b1);
    step();
    step();

    for (int n = 0; n < 200; n++) begin
      r_we   = 1'($urandom);
      r_size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r_addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
      xact(r_we, r_addr, r_size, 1'($urandom), $urandom, $urandom_range(0, 3), 1'b0);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter STORE_ACK, default 1: 1 = stores return a response; 0 = stores complete silently.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port resetb  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  in  1  core request present.
REQ-005 SHALL have port req_ready  out  1  request accepted when high together with req_valid.
REQ-006 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  in  32  byte address.
REQ-008 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  out  1  response present.
REQ-012 SHALL have port rsp_ready  in  1  response consumed when high together with rsp_valid.
REQ-013 SHALL have port rsp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  out  1  misaligned or illegal-size request.
REQ-015 SHALL have ports mem_rready out 1, mem_wready out 1, mem_raddr out 30 ([31:2]), mem_waddr out 30 ([31:2]), mem_wdata out 32, mem_wstrb out 4, mem_rdata in 32; word-addressed memory, registered read data valid one cycle after mem_rready.

Function
REQ-016 SHALL implement FSM IDLE, RD, RSP; req_ready = (state == IDLE).
REQ-017 SHALL define accept = req_valid & req_ready; at accept, register addr[1:0], size, unsigned, we.
REQ-018 SHALL flag misaligned: half with addr[0]=1, word with addr[1:0]!=0; size 11 is always an error.
REQ-019 SHALL, on an erroneous accept, issue no memory access, go to RSP with rsp_err=1 and rsp_rdata=0 (rsp_valid at N+1 if accepted in cycle N).
REQ-020 SHALL, on a legal load accept, assert mem_rready combinationally in that cycle with mem_raddr = req_addr[31:2], and go to RD.
REQ-021 SHALL, in RD, capture mem_rdata shifted right by 8*addr[1:0], masked to size, and extended per unsigned into rsp_rdata, then go to RSP; rsp_valid at N+2.
REQ-022 SHALL, on a legal store accept, assert mem_wready combinationally in that cycle with mem_waddr = req_addr[31:2].
REQ-023 SHALL drive mem_wstrb: byte 0001<<addr[1:0], half 0011<<addr[1:0], word 1111.
REQ-024 SHALL drive mem_wdata: byte replicated x4, half replicated x2, word unchanged.
REQ-025 SHALL, after a store, go to RSP (rsp_err=0, rsp_rdata=0) when STORE_ACK=1, else stay in IDLE with req_ready high next cycle.
REQ-026 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RSP until rsp_ready; on handshake go to IDLE.
REQ-027 SHALL keep mem_rready, mem_wready and mem_wstrb at 0 outside an accept cycle; mem_raddr and mem_waddr follow req_addr[31:2].
REQ-028 SHALL ignore req_* while not in IDLE; no request queuing.
REQ-029 SHALL guarantee mem_rready and mem_wready are never high in the same cycle.

Reset
REQ-030 SHALL, while resetb=0, force state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, and mem_rready=mem_wready=0, mem_wstrb=0.
REQ-031 SHALL, on reset during RD or RSP, drop the pending response; memory writes already issued are not undone.
REQ-032 SHALL leave req_ready low while resetb=0 and raise it the first cycle after release.

Verification
REQ-033 SHALL cover store word 0x11223344 to 0x100, then load word 0x100 -> wstrb 1111, waddr 0x40; rsp_rdata 0x11223344 at N+2, rsp_err 0.
REQ-034 SHALL cover load byte signed at 0x103, memory word 0x80FF0000 -> rsp_rdata 0xFFFFFF80; unsigned -> 0x00000080.
REQ-035 SHALL cover store half 0xBEEF to 0x102 -> wstrb 1100, wdata 0xBEEFBEEF; reload word shows upper half 0xBEEF, lower half unchanged.
REQ-036 SHALL cover load word at 0x101 and size 11 at 0x0 -> no mem_rready/mem_wready, rsp_err 1, rsp_rdata 0 at N+1.
REQ-037 SHALL cover rsp_ready held low 5 cycles -> rsp_valid and data stable, req_ready 0 throughout; release -> IDLE next cycle.
REQ-038 SHALL cover resetb pulsed low during RD -> rsp_valid stays 0, req_ready 1 the cycle after release.
